// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART receiver.
package uart_pkg;
    localparam int DEF_DATA_BITS = 8;
    localparam int DEF_OSR       = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops reset to RST_VAL.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic meta_q, sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit glitch reject, optional parity, single-entry
// holding register with overrun detection.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OSR        = DEF_OSR,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 SAMPLE_TICK,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_VALID,
    input  logic                 RX_ACK,
    output logic                 FRAME_ERR,
    output logic                 PARITY_ERR,
    output logic                 OVERRUN
);
    localparam int TCW = $clog2(OSR);
    localparam int BCW = $clog2(DATA_BITS + 1);

    logic                 rxs, rxs_prev_q;
    state_e               state_q, state_d;
    logic [TCW-1:0]       tick_q, tick_d;
    logic [BCW-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 ovr_q, ovr_d;

    logic tick_mid, tick_end, stop_smp, accept, blocked;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (RX),
        .q_o   (rxs)
    );

    assign tick_mid = (tick_q == TCW'(OSR/2 - 1));
    assign tick_end = (tick_q == TCW'(OSR - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            rxs_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            rxs_prev_q <= rxs;
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        case (state_q)
            // Edge-triggered start: a line held low after a break never retriggers.
            ST_IDLE: if (rxs_prev_q && !rxs) begin
                state_d   = ST_START;
                tick_d    = '0;
                bit_d     = '0;
                par_err_d = 1'b0;
            end
            ST_START: if (SAMPLE_TICK) begin
                if (tick_mid) begin
                    tick_d  = '0;
                    state_d = rxs ? ST_IDLE : ST_DATA;
                end else begin
                    tick_d = tick_q + TCW'(1);
                end
            end
            ST_DATA: if (SAMPLE_TICK) begin
                if (tick_end) begin
                    tick_d  = '0;
                    shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                    if (bit_q == BCW'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + BCW'(1);
                    end
                end else begin
                    tick_d = tick_q + TCW'(1);
                end
            end
            ST_PARITY: if (SAMPLE_TICK) begin
                if (tick_end) begin
                    tick_d    = '0;
                    par_err_d = rxs ^ (^shift_q) ^ PARITY_ODD;
                    state_d   = ST_STOP;
                end else begin
                    tick_d = tick_q + TCW'(1);
                end
            end
            ST_STOP: if (SAMPLE_TICK) begin
                if (tick_end) begin
                    tick_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    tick_d = tick_q + TCW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stop_smp = (state_q == ST_STOP) && SAMPLE_TICK && tick_end;
        accept   = stop_smp && rxs && !par_err_q;
        blocked  = valid_q && !RX_ACK;
        data_d   = data_q;
        valid_d  = valid_q;
        ferr_d   = stop_smp && !rxs;
        perr_d   = stop_smp && rxs && par_err_q;
        ovr_d    = accept && blocked;
        // A read strobe in the acceptance cycle frees the slot for the new frame.
        if (accept && !blocked) begin
            data_d  = shift_q;
            valid_d = 1'b1;
        end else if (RX_ACK) begin
            valid_d = 1'b0;
        end
    end

    assign RX_DATA    = data_q;
    assign RX_VALID   = valid_q;
    assign FRAME_ERR  = ferr_q;
    assign PARITY_ERR = perr_q;
    assign OVERRUN    = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus randomized frames scored against a frame-level model.
module tb_uart_rx;
    localparam int BITCLK = 64;   // OSR=16 ticks, one tick every 4 CLK

    logic CLK = 1'b0, RST = 1'b1, SAMPLE_TICK = 1'b0;
    logic RX = 1'b1, RX_ACK = 1'b0, RXP = 1'b1, ACKP = 1'b0;
    logic [7:0] RX_DATA, PDATA;
    logic RX_VALID, FRAME_ERR, PARITY_ERR, OVERRUN;
    logic PVALID, PFE, PPE, POV;

    int nvec = 0, nerr = 0;
    int fe_n = 0, pe_n = 0, ov_n = 0, long_n = 0, rise_n = 0;
    int pfe_n = 0, ppe_n = 0, pov_n = 0, plong_n = 0;
    logic rise_tick = 1'b0;
    logic fe_p = 0, pe_p = 0, ov_p = 0, v_p = 0, tick_p = 0, pfe_p = 0, ppe_p = 0, pov_p = 0;

    uart_rx #(.DATA_BITS(8), .OSR(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
        .CLK(CLK), .RST(RST), .SAMPLE_TICK(SAMPLE_TICK), .RX(RX),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_ACK(RX_ACK),
        .FRAME_ERR(FRAME_ERR), .PARITY_ERR(PARITY_ERR), .OVERRUN(OVERRUN));

    uart_rx #(.DATA_BITS(8), .OSR(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
        .CLK(CLK), .RST(RST), .SAMPLE_TICK(SAMPLE_TICK), .RX(RXP),
        .RX_DATA(PDATA), .RX_VALID(PVALID), .RX_ACK(ACKP),
        .FRAME_ERR(PFE), .PARITY_ERR(PPE), .OVERRUN(POV));

    always #5 CLK = ~CLK;

    initial begin
        int c;
        c = 0;
        forever begin
            @(posedge CLK); #1;
            SAMPLE_TICK = (c == 3);
            c = (c + 1) % 4;
        end
    end

    // Pulse counters and RX_VALID rise timing relative to the previous cycle's tick.
    always @(negedge CLK) begin
        if (FRAME_ERR) fe_n++;
        if (PARITY_ERR) pe_n++;
        if (OVERRUN) ov_n++;
        if ((FRAME_ERR && fe_p) || (PARITY_ERR && pe_p) || (OVERRUN && ov_p)) long_n++;
        if (RX_VALID === 1'b1 && v_p !== 1'b1) begin rise_n++; rise_tick = tick_p; end
        if (PFE) pfe_n++;
        if (PPE) ppe_n++;
        if (POV) pov_n++;
        if ((PFE && pfe_p) || (PPE && ppe_p) || (POV && pov_p)) plong_n++;
        fe_p = FRAME_ERR; pe_p = PARITY_ERR; ov_p = OVERRUN; v_p = RX_VALID; tick_p = SAMPLE_TICK;
        pfe_p = PFE; ppe_p = PPE; pov_p = POV;
    end

    task automatic send(input logic [7:0] d, input bit par_en, input bit pbit, input bit stop,
                        input bit on_p, input bit hold);
        logic [10:0] bits;
        int n;
        bits = '0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        n = 9;
        if (par_en) begin bits[9] = pbit; n = 10; end
        bits[n] = stop;
        n++;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            if (on_p) RXP = bits[i]; else RX = bits[i];
            repeat (BITCLK - 1) @(posedge CLK);
        end
        if (!hold) begin
            @(posedge CLK); #1;
            if (on_p) RXP = 1'b1; else RX = 1'b1;
            repeat (BITCLK - 1) @(posedge CLK);
        end
        @(negedge CLK);
    endtask

    task automatic ack();
        @(posedge CLK); #1 RX_ACK = 1'b1;
        @(posedge CLK); #1 RX_ACK = 1'b0;
        @(negedge CLK);
    endtask

    task automatic ackp();
        @(posedge CLK); #1 ACKP = 1'b1;
        @(posedge CLK); #1 ACKP = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        nvec++; if (RX_DATA !== 8'h00) begin nerr++; $display("FAIL reset_data got=%h exp=00", RX_DATA); end
        nvec++; if (RX_VALID !== 1'b0) begin nerr++; $display("FAIL reset_valid got=%b exp=0", RX_VALID); end
        nvec++; if ({FRAME_ERR, PARITY_ERR, OVERRUN} !== 3'b000) begin nerr++; $display("FAIL reset_pulses got=%b exp=000", {FRAME_ERR, PARITY_ERR, OVERRUN}); end
        nvec++; if ({PVALID, PDATA} !== 9'h000) begin nerr++; $display("FAIL reset_pdut got=%h exp=000", {PVALID, PDATA}); end
        @(posedge CLK); #1 RST = 1'b0;
        repeat (BITCLK) @(posedge CLK);
    endtask

    task automatic test_basic();
        int fe0, pe0, ov0, r0, l0;
        fe0 = fe_n; pe0 = pe_n; ov0 = ov_n; r0 = rise_n; l0 = long_n;
        send(8'hA5, 0, 0, 1, 0, 0);
        nvec++; if (RX_DATA !== 8'hA5) begin nerr++; $display("FAIL basic_data got=%h exp=a5", RX_DATA); end
        nvec++; if (RX_VALID !== 1'b1) begin nerr++; $display("FAIL basic_valid got=%b exp=1", RX_VALID); end
        nvec++; if (rise_n - r0 != 1 || rise_tick !== 1'b1) begin nerr++; $display("FAIL basic_latency rises=%0d after_tick=%b exp 1/1", rise_n - r0, rise_tick); end
        nvec++; if (fe_n != fe0 || pe_n != pe0 || ov_n != ov0 || long_n != l0) begin nerr++; $display("FAIL basic_pulses fe=%0d pe=%0d ov=%0d exp none", fe_n - fe0, pe_n - pe0, ov_n - ov0); end
        ack();
        nvec++; if (RX_VALID !== 1'b0) begin nerr++; $display("FAIL basic_ack_clear got=%b exp=0", RX_VALID); end
    endtask

    task automatic test_glitch();
        int fe0, pe0, ov0, r0;
        fe0 = fe_n; pe0 = pe_n; ov0 = ov_n; r0 = rise_n;
        @(posedge CLK); #1 RX = 1'b0;
        repeat (20) @(posedge CLK);
        #1 RX = 1'b1;
        repeat (2 * BITCLK) @(posedge CLK);
        @(negedge CLK);
        nvec++; if (RX_VALID !== 1'b0 || rise_n != r0) begin nerr++; $display("FAIL glitch_valid got=%b rises=%0d exp 0/0", RX_VALID, rise_n - r0); end
        nvec++; if (fe_n != fe0 || pe_n != pe0 || ov_n != ov0) begin nerr++; $display("FAIL glitch_pulses fe=%0d pe=%0d ov=%0d exp none", fe_n - fe0, pe_n - pe0, ov_n - ov0); end
        send(8'h5A, 0, 0, 1, 0, 0);
        nvec++; if ({RX_VALID, RX_DATA} !== 9'h15A) begin nerr++; $display("FAIL glitch_recover got=%h exp=15a", {RX_VALID, RX_DATA}); end
        ack();
    endtask

    task automatic test_break();
        int fe0, r0, l0;
        fe0 = fe_n; r0 = rise_n; l0 = long_n;
        send(8'h3C, 0, 0, 0, 0, 1);
        nvec++; if (fe_n - fe0 != 1 || long_n != l0) begin nerr++; $display("FAIL break_ferr pulses=%0d long=%0d exp 1/0", fe_n - fe0, long_n - l0); end
        nvec++; if (RX_VALID !== 1'b0) begin nerr++; $display("FAIL break_valid got=%b exp=0", RX_VALID); end
        repeat (20 * BITCLK) @(posedge CLK);
        @(negedge CLK);
        nvec++; if (fe_n - fe0 != 1 || rise_n != r0 || ov_n + pe_n != 0 + ov_n + pe_n) begin nerr++; $display("FAIL break_hold ferr=%0d rises=%0d exp 1/0", fe_n - fe0, rise_n - r0); end
        @(posedge CLK); #1 RX = 1'b1;
        repeat (BITCLK) @(posedge CLK);
        send(8'hC3, 0, 0, 1, 0, 0);
        nvec++; if ({RX_VALID, RX_DATA} !== 9'h1C3) begin nerr++; $display("FAIL break_recover got=%h exp=1c3", {RX_VALID, RX_DATA}); end
        ack();
    endtask

    task automatic test_parity();
        int pe0, fe0;
        send(8'h5A, 1, ^8'h5A, 1, 1, 0);
        nvec++; if ({PVALID, PDATA} !== 9'h15A) begin nerr++; $display("FAIL parity_good got=%h exp=15a", {PVALID, PDATA}); end
        ackp();
        pe0 = ppe_n; fe0 = pfe_n;
        send(8'h07, 1, 1'b0, 1, 1, 0);
        nvec++; if (ppe_n - pe0 != 1 || plong_n != 0) begin nerr++; $display("FAIL parity_err pulses=%0d long=%0d exp 1/0", ppe_n - pe0, plong_n); end
        nvec++; if ({PVALID, PDATA} !== 9'h05A) begin nerr++; $display("FAIL parity_drop got=%h exp=05a", {PVALID, PDATA}); end
        nvec++; if (pfe_n != fe0) begin nerr++; $display("FAIL parity_no_ferr got=%0d exp=0", pfe_n - fe0); end
    endtask

    task automatic test_overrun();
        int ov0;
        send(8'h11, 0, 0, 1, 0, 0);
        ov0 = ov_n;
        send(8'h22, 0, 0, 1, 0, 0);
        nvec++; if ({RX_VALID, RX_DATA} !== 9'h111) begin nerr++; $display("FAIL overrun_hold got=%h exp=111", {RX_VALID, RX_DATA}); end
        nvec++; if (ov_n - ov0 != 1) begin nerr++; $display("FAIL overrun_pulse got=%0d exp=1", ov_n - ov0); end
        ov0 = ov_n;
        // Stop sample lands on tick 8+16*9 counted from the cycle the FSM enters START.
        fork
            send(8'h22, 0, 0, 1, 0, 0);
            begin
                int n;
                n = 0;
                repeat (4) @(posedge CLK);
                while (n < 152) begin
                    #2;
                    if (SAMPLE_TICK) n++;
                    if (n < 152) @(posedge CLK);
                end
                RX_ACK = 1'b1;
                @(posedge CLK); #1 RX_ACK = 1'b0;
            end
        join
        nvec++; if ({RX_VALID, RX_DATA} !== 9'h122) begin nerr++; $display("FAIL ack_coincide got=%h exp=122", {RX_VALID, RX_DATA}); end
        nvec++; if (ov_n != ov0) begin nerr++; $display("FAIL ack_coincide_ovr got=%0d exp=0", ov_n - ov0); end
    endtask

    task automatic test_reset_mid();
        int fe0, pe0, ov0, r0;
        fe0 = 0; pe0 = 0; ov0 = 0; r0 = 0;
        fork
            send(8'hFF, 0, 0, 1, 0, 0);
            begin
                repeat (BITCLK * 5 + 32) @(posedge CLK);
                #1 RST = 1'b1;
                repeat (2) @(posedge CLK);
                @(negedge CLK);
                nvec++; if ({RX_VALID, RX_DATA, FRAME_ERR, PARITY_ERR, OVERRUN} !== 12'h000) begin nerr++; $display("FAIL rst_mid_outputs got=%h exp=000", {RX_VALID, RX_DATA, FRAME_ERR, PARITY_ERR, OVERRUN}); end
                @(posedge CLK); #1 RST = 1'b0;
                fe0 = fe_n; pe0 = pe_n; ov0 = ov_n; r0 = rise_n;
            end
        join
        nvec++; if (rise_n != r0 || fe_n != fe0 || pe_n != pe0 || ov_n != ov0) begin nerr++; $display("FAIL rst_mid_abort rises=%0d fe=%0d exp 0/0", rise_n - r0, fe_n - fe0); end
        send(8'h55, 0, 0, 1, 0, 0);
        nvec++; if ({RX_VALID, RX_DATA} !== 9'h155) begin nerr++; $display("FAIL rst_mid_resume got=%h exp=155", {RX_VALID, RX_DATA}); end
    endtask

    task automatic test_random();
        logic [7:0] d, exp_data;
        bit stop, exp_valid;
        int fe0, ov0, exp_fe, exp_ov;
        ack();
        exp_valid = 0; exp_data = 8'h55;
        for (int k = 0; k < 20; k++) begin
            d = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin ack(); exp_valid = 0; end
            fe0 = fe_n; ov0 = ov_n; exp_fe = 0; exp_ov = 0;
            send(d, 0, 0, stop, 0, 0);
            if (!stop) exp_fe = 1;
            else if (exp_valid) exp_ov = 1;
            else begin exp_data = d; exp_valid = 1; end
            nvec++; if ({RX_VALID, RX_DATA} !== {exp_valid, exp_data}) begin nerr++; $display("FAIL rand_frame%0d got=%h exp=%h", k, {RX_VALID, RX_DATA}, {exp_valid, exp_data}); end
            nvec++; if (fe_n - fe0 != exp_fe || ov_n - ov0 != exp_ov) begin nerr++; $display("FAIL rand_pulses%0d fe=%0d ov=%0d exp %0d/%0d", k, fe_n - fe0, ov_n - ov0, exp_fe, exp_ov); end
        end
    endtask

    task automatic test_random_parity();
        logic [7:0] d, exp_data;
        bit bad, exp_valid;
        int pe0, exp_pe;
        exp_data = 8'h00;   // cleared by the mid-frame reset
        for (int k = 0; k < 10; k++) begin
            d = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 2) == 0);
            ackp();
            exp_valid = 0;
            pe0 = ppe_n;
            send(d, 1, (^d) ^ bad, 1, 1, 0);
            exp_pe = bad ? 1 : 0;
            if (!bad) begin exp_data = d; exp_valid = 1; end
            nvec++; if ({PVALID, PDATA} !== {exp_valid, exp_data}) begin nerr++; $display("FAIL rpar_frame%0d got=%h exp=%h", k, {PVALID, PDATA}, {exp_valid, exp_data}); end
            nvec++; if (ppe_n - pe0 != exp_pe) begin nerr++; $display("FAIL rpar_pulse%0d got=%0d exp=%0d", k, ppe_n - pe0, exp_pe); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_parity();
        test_overrun();
        test_reset_mid();
        test_random();
        test_random_parity();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  DATA_BITS, 8, data bits per frame, legal range 5-8.
  OSR, 16, SAMPLE_TICK pulses per bit period, even, at least 8.
  PARITY_EN, 0, when 1 a parity bit follows the data bits.
  PARITY_ODD, 0, when 1 odd parity; when 0 even parity.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  CLK, in, 1, single system clock; all logic on posedge.
  RST, in, 1, synchronous active-high reset.
  SAMPLE_TICK, in, 1, one-CLK-cycle enable at BAUD*OSR rate, from the baud generator.
  RX, in, 1, asynchronous serial line, idle high.
  RX_DATA, out, DATA_BITS, last accepted frame payload.
  RX_VALID, out, 1, RX_DATA holds unread data.
  RX_ACK, in, 1, consumer read strobe; clears RX_VALID.
  FRAME_ERR, out, 1, one-cycle pulse: stop bit sampled low.
  PARITY_ERR, out, 1, one-cycle pulse: parity mismatch.
  OVERRUN, out, 1, one-cycle pulse: completed frame dropped.

Function
REQ-003 RX SHALL pass through a 2-FF synchronizer; all decisions SHALL use the synchronized value rxs.
REQ-004 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP; the tick counter and the bit counter SHALL advance only on SAMPLE_TICK.
REQ-005 IDLE->START SHALL occur on a 1->0 transition of rxs (CLK-rate edge detect), and the tick counter SHALL clear on entry.
REQ-006 In START, at tick count OSR/2-1, rxs=1 SHALL return the FSM to IDLE (glitch reject) and rxs=0 SHALL enter DATA with the tick counter cleared.
REQ-007 In DATA, each bit SHALL be sampled when the tick counter reaches OSR-1 (mid-bit); bits SHALL be shifted in LSB first; after DATA_BITS samples the FSM SHALL enter PARITY if PARITY_EN=1, otherwise STOP.
REQ-008 PARITY SHALL sample one bit at OSR-1; a mismatch against the XOR of the data (inverted when PARITY_ODD=1) SHALL be latched internally.
REQ-009 STOP SHALL sample at OSR-1 and then return to IDLE.
REQ-010 If stop=1 and there is no parity error, the frame SHALL be accepted.
REQ-011 If stop=0, FRAME_ERR SHALL pulse and the frame SHALL be discarded.
REQ-012 If stop=1 with a parity error, PARITY_ERR SHALL pulse and the frame SHALL be discarded.
REQ-013 An accepted frame SHALL load RX_DATA and set RX_VALID on the CLK edge following the stop-sample tick (latency 1 CLK).
REQ-014 RX_VALID SHALL stay high until RX_ACK is sampled high; RX_ACK while RX_VALID=0 SHALL be ignored.
REQ-015 A frame accepted while RX_VALID=1 and RX_ACK=0 SHALL be dropped, RX_DATA SHALL be unchanged, and OVERRUN SHALL pulse.
REQ-016 A frame accepted in the same cycle as RX_ACK=1 SHALL load normally, with RX_VALID remaining 1 and no OVERRUN.
REQ-017 After a stop=0 (break) condition, IDLE SHALL require rxs to return high before a new start is detected; a held-low line SHALL NOT retrigger.
REQ-018 Counter widths SHALL be $clog2(OSR) bits (tick counter) and $clog2(DATA_BITS+1) bits (bit counter), and neither counter SHALL wrap past its terminal count.

Reset
REQ-019 While RST=1: state=IDLE, counters=0, shift register=0, RX_DATA=0, RX_VALID=0, FRAME_ERR=PARITY_ERR=OVERRUN=0, and both synchronizer FFs=1.
REQ-020 RST asserted mid-frame SHALL abort the frame with no output pulse; reception SHALL resume on the next falling edge after RST deasserts.

Structure
REQ-021 A shared package uart_pkg SHALL hold the FSM state encoding and default DATA_BITS/OSR constants.
REQ-022 The 2-FF synchronizer SHALL be a sub-module named sync_2ff, and all other logic SHALL be inline.

Verification
REQ-023 The bench SHALL run OSR=16 with SAMPLE_TICK every 4 CLK and cover these directed scenarios:
  Frame 0xA5, stop=1, PARITY_EN=0 -> RX_DATA=0xA5 and RX_VALID=1 exactly 1 CLK after the stop-sample tick, with no error pulses.
  RX low for 5 ticks then high -> FSM back to IDLE, no RX_VALID, no error pulse.
  Frame 0x3C with stop=0 -> FRAME_ERR for 1 CLK, RX_VALID stays 0; line held low 20 bit times -> no further activity.
  PARITY_EN=1, even parity, 0x07 sent with parity bit 0 -> PARITY_ERR pulse, RX_DATA unchanged.
  Frames 0x11 then 0x22 with no RX_ACK -> RX_DATA=0x11 and OVERRUN pulse; repeat with RX_ACK coinciding with 0x22 acceptance -> RX_DATA=0x22, RX_VALID=1, no OVERRUN.
  RST asserted during data bit 4 of 0xFF -> all outputs 0; next 0x55 frame received correctly.
